// File: rtl/mc_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset controller.
// Holds the state encoding, opcode/funct constants, ALU op codes and the control bundle.
package mc_control_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned FN_W     = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2b;

    localparam logic [FN_W-1:0] FN_ADD = 6'h20;
    localparam logic [FN_W-1:0] FN_SUB = 6'h22;
    localparam logic [FN_W-1:0] FN_AND = 6'h24;
    localparam logic [FN_W-1:0] FN_OR  = 6'h25;
    localparam logic [FN_W-1:0] FN_SLT = 6'h2a;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic                reg_dst;
        logic                reg_write;
        logic                alu_src;
        logic                mem2reg;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic                intr;
        logic [ALU_OP_W-1:0] op;
        logic                ir_write;
        logic                pc_write;
        logic                retire;
        logic                illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle; master is the controller, slave is the datapath side.
// cnt_load/cnt_load_val let the datapath or a debugger preload the retire counter.
interface mc_control_if;
    logic [31:0] ins;
    logic        zero;
    logic        mem_ready;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrc;
    logic        Mem2Reg;
    logic        MemRead;
    logic        MemWrite;
    logic        branch;
    logic        jump;
    logic        INT;
    logic [2:0]  op;
    logic        ir_write;
    logic        pc_write;
    logic        retire;
    logic        illegal;
    logic [15:0] instr_count;
    logic [2:0]  state;
    logic        cnt_load;
    logic [15:0] cnt_load_val;

    modport master (
        input  ins, zero, mem_ready, cnt_load, cnt_load_val,
        output RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, branch, jump, INT,
        output op, ir_write, pc_write, retire, illegal, instr_count, state
    );

    modport slave (
        output ins, zero, mem_ready, cnt_load, cnt_load_val,
        input  RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, branch, jump, INT,
        input  op, ir_write, pc_write, retire, illegal, instr_count, state
    );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational ALU-op decode from opcode and funct; funct_ok flags unsupported R-type functs.
module mc_alu_decode
    import mc_control_pkg::*;
(
    input  logic [OPC_W-1:0]    opcode_i,
    input  logic [FN_W-1:0]     funct_i,
    output logic [ALU_OP_W-1:0] op_o,
    output logic                funct_ok_o
);

    always_comb begin
        op_o       = ALU_ADD;
        funct_ok_o = 1'b1;
        unique case (opcode_i)
            OPC_RTYPE: begin
                unique case (funct_i)
                    FN_ADD:  op_o = ALU_ADD;
                    FN_SUB:  op_o = ALU_SUB;
                    FN_AND:  op_o = ALU_AND;
                    FN_OR:   op_o = ALU_OR;
                    FN_SLT:  op_o = ALU_SLT;
                    default: begin
                        op_o       = ALU_AND;
                        funct_ok_o = 1'b0;
                    end
                endcase
            end
            OPC_BEQ: op_o = ALU_SUB;
            default: op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle controller: BOOT/FETCH/DECODE/EXEC/MEM/WB sequencing with Moore
// control decode from the registered state and IR; memory handshake on mem_ready.
module mc_control
    import mc_control_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mc_control_if.master ctl
);

    state_e              state_q, state_d;
    logic [XLEN-1:0]     ir_q, ir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    ctrl_t               ctrl_c;
    logic [OPC_W-1:0]    opc;
    logic [ALU_OP_W-1:0] alu_op;
    logic                funct_ok;
    logic                is_r, is_beq, is_lw, is_sw;
    logic                unused_c;

    assign opc    = ir_q[XLEN-1:XLEN-OPC_W];
    assign is_r   = (opc == OPC_RTYPE);
    assign is_beq = (opc == OPC_BEQ);
    assign is_lw  = (opc == OPC_LW);
    assign is_sw  = (opc == OPC_SW);

    // The zero flag is consumed by the PC logic, not here.
    assign unused_c = ^{ctl.zero, ir_q[25:6]};

    mc_alu_decode u_alu_decode (
        .opcode_i   (opc),
        .funct_i    (ir_q[FN_W-1:0]),
        .op_o       (alu_op),
        .funct_ok_o (funct_ok)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        ctrl_c  = '0;
        unique case (state_q)
            ST_BOOT: begin
                ctrl_c.intr     = 1'b1;
                ctrl_c.pc_write = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_FETCH: begin
                ctrl_c.ir_write = 1'b1;
                ir_d            = ctl.ins;
                state_d         = ST_DECODE;
            end
            ST_DECODE: begin
                unique case (opc)
                    OPC_J: begin
                        ctrl_c.jump     = 1'b1;
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.retire   = 1'b1;
                        state_d         = ST_FETCH;
                    end
                    OPC_RTYPE: begin
                        if (funct_ok) begin
                            state_d = ST_EXEC;
                        end else begin
                            // Bad funct retires as a no-op so software sees progress.
                            ctrl_c.illegal  = 1'b1;
                            ctrl_c.pc_write = 1'b1;
                            ctrl_c.retire   = 1'b1;
                            state_d         = ST_FETCH;
                        end
                    end
                    OPC_BEQ, OPC_ADDI, OPC_LW, OPC_SW: state_d = ST_EXEC;
                    default: begin
                        ctrl_c.illegal  = 1'b1;
                        ctrl_c.pc_write = 1'b1;
                        state_d         = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC: begin
                ctrl_c.alu_src = !(is_r || is_beq);
                ctrl_c.op      = alu_op;
                if (is_beq) begin
                    ctrl_c.branch   = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.retire   = 1'b1;
                    state_d         = ST_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (is_lw) begin
                    ctrl_c.mem_read = 1'b1;
                    if (ctl.mem_ready) state_d = ST_WB;
                end else if (ctl.mem_ready) begin
                    ctrl_c.mem_write = 1'b1;
                    ctrl_c.pc_write  = 1'b1;
                    ctrl_c.retire    = 1'b1;
                    state_d          = ST_FETCH;
                end
            end
            ST_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.retire    = 1'b1;
                ctrl_c.reg_dst   = is_r;
                ctrl_c.mem2reg   = is_lw;
                ctrl_c.op        = alu_op;
                state_d          = ST_FETCH;
            end
            default: state_d = ST_BOOT;
        endcase

        // Reset squashes every strobe on the aborting edge.
        if (!rst_n) ctrl_c = '0;

        if (ctl.cnt_load)      cnt_d = ctl.cnt_load_val;
        else if (ctrl_c.retire) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctl.RegDst      = ctrl_c.reg_dst;
    assign ctl.RegWrite    = ctrl_c.reg_write;
    assign ctl.ALUSrc      = ctrl_c.alu_src;
    assign ctl.Mem2Reg     = ctrl_c.mem2reg;
    assign ctl.MemRead     = ctrl_c.mem_read;
    assign ctl.MemWrite    = ctrl_c.mem_write;
    assign ctl.branch      = ctrl_c.branch;
    assign ctl.jump        = ctrl_c.jump;
    assign ctl.INT         = ctrl_c.intr;
    assign ctl.op          = ctrl_c.op;
    assign ctl.ir_write    = ctrl_c.ir_write;
    assign ctl.pc_write    = ctrl_c.pc_write;
    assign ctl.retire      = ctrl_c.retire;
    assign ctl.illegal     = ctrl_c.illegal;
    assign ctl.instr_count = cnt_q;
    assign ctl.state       = rst_n ? state_q : ST_BOOT;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: each instruction is expanded into its expected
// per-cycle control trace from the instruction-class rules and compared cycle by cycle.
module tb_mc_control;
    import mc_control_pkg::*;

    typedef struct packed {
        logic [2:0] state;
        logic       reg_dst, reg_write, alu_src, mem2reg, mem_read, mem_write, branch, jump, intr;
        logic [2:0] op;
        logic       ir_write, pc_write, retire, illegal;
    } obs_t;

    logic        clk;
    logic        rst_n;
    int          n_cmp;
    int          n_bad;
    logic [15:0] exp_cnt;
    logic [5:0]  legal_fn [0:4] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    mc_control_if bus ();

    mc_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t s;
        s.state     = bus.state;
        s.reg_dst   = bus.RegDst;
        s.reg_write = bus.RegWrite;
        s.alu_src   = bus.ALUSrc;
        s.mem2reg   = bus.Mem2Reg;
        s.mem_read  = bus.MemRead;
        s.mem_write = bus.MemWrite;
        s.branch    = bus.branch;
        s.jump      = bus.jump;
        s.intr      = bus.INT;
        s.op        = bus.op;
        s.ir_write  = bus.ir_write;
        s.pc_write  = bus.pc_write;
        s.retire    = bus.retire;
        s.illegal   = bus.illegal;
        return s;
    endfunction

    // {supported, alu op} straight from the instruction-set table.
    function automatic logic [3:0] alu_ref(input logic [31:0] w);
        logic [3:0] r;
        r = 4'b0000;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20:   r = 4'b1010;
                6'h22:   r = 4'b1110;
                6'h24:   r = 4'b1000;
                6'h25:   r = 4'b1001;
                6'h2a:   r = 4'b1111;
                default: r = 4'b0000;
            endcase
            6'h04:               r = 4'b1110;
            6'h08, 6'h23, 6'h2b: r = 4'b1010;
            default:             r = 4'b0000;
        endcase
        return r;
    endfunction

    task automatic run_instr(input logic [31:0] w, input int stall, input int abort_at);
        obs_t       q[$];
        obs_t       e;
        logic [5:0] opc;
        logic [3:0] a;
        logic       r, lw, sw, beq, legal;
        int         m;
        opc   = w[31:26];
        a     = alu_ref(w);
        r     = (opc == 6'h00);
        lw    = (opc == 6'h23);
        sw    = (opc == 6'h2b);
        beq   = (opc == 6'h04);
        legal = opc inside {6'h00, 6'h04, 6'h08, 6'h23, 6'h2b};

        e = '0; e.state = ST_FETCH; e.ir_write = 1'b1; q.push_back(e);
        e = '0; e.state = ST_DECODE;
        if (opc == 6'h02) begin
            e.jump = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1; q.push_back(e);
        end else if (!legal || (r && !a[3])) begin
            e.illegal = 1'b1; e.pc_write = 1'b1; e.retire = r; q.push_back(e);
        end else begin
            q.push_back(e);
            e = '0; e.state = ST_EXEC; e.op = a[2:0]; e.alu_src = !(r || beq);
            if (beq) begin e.branch = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1; end
            q.push_back(e);
            if (lw || sw) begin
                for (int i = 0; i <= stall; i++) begin
                    e = '0; e.state = ST_MEM; e.mem_read = lw;
                    if (sw && i == stall) begin
                        e.mem_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
                    end
                    q.push_back(e);
                end
            end
            if (!beq && !sw) begin
                e = '0; e.state = ST_WB; e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
                e.reg_dst = r; e.mem2reg = lw; e.op = a[2:0];
                q.push_back(e);
            end
        end

        m = 0;
        foreach (q[i]) begin
            if (i == abort_at) return;
            bus.ins  = (i == 0) ? w : $urandom;
            bus.zero = 1'($urandom);
            if (q[i].state == ST_MEM) begin
                bus.mem_ready = (m == stall);
                m++;
            end else begin
                bus.mem_ready = 1'($urandom);
            end
            @(negedge clk);
            chk($sformatf("%08h cyc%0d ctrl", w, i), 32'(sample()), 32'(q[i]));
            if (q[i].retire) exp_cnt++;
            @(posedge clk); #1;
        end
        chk($sformatf("%08h instr_count", w), 32'(bus.instr_count), 32'(exp_cnt));
    endtask

    task automatic do_reset(input logic [15:0] preload, input logic load);
        obs_t z;
        z = '0; z.state = ST_BOOT;
        rst_n = 1'b0; bus.mem_ready = 1'b1; bus.ins = $urandom; bus.cnt_load = 1'b0;
        @(negedge clk);
        chk("reset outputs", 32'(sample()), 32'(z));
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset hold outputs", 32'(sample()), 32'(z));
        chk("reset instr_count", 32'(bus.instr_count), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus.cnt_load = load; bus.cnt_load_val = preload;
        z.intr = 1'b1; z.pc_write = 1'b1;
        @(negedge clk);
        chk("boot outputs", 32'(sample()), 32'(z));
        exp_cnt = load ? preload : 16'h0;
        @(posedge clk); #1;
        bus.cnt_load = 1'b0;
        chk("boot instr_count", 32'(bus.instr_count), 32'(exp_cnt));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; exp_cnt = '0;
        rst_n = 1'b0;
        bus.ins = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        bus.cnt_load = 1'b0; bus.cnt_load_val = '0;

        do_reset(16'h0, 1'b0);
        run_instr(32'h01095020, 0, -1);
        run_instr(32'h8D090004, 3, -1);
        run_instr(32'h1109FFFE, 0, -1);
        run_instr(32'h08000020, 0, -1);
        run_instr(32'hFC000000, 0, -1);
        run_instr(32'h0109503F, 0, -1);
        run_instr(32'h01095022, 0, -1);
        run_instr(32'h01095024, 0, -1);
        run_instr(32'h01095025, 0, -1);
        run_instr(32'h0109502A, 0, -1);
        run_instr(32'h21090005, 0, -1);
        run_instr(32'hAD090008, 2, -1);
        run_instr(32'h8D090004, 0, -1);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] w;
            int          c;
            c = $urandom_range(0, 7);
            w = $urandom;
            case (c)
                0: begin w[31:26] = 6'h00; w[5:0] = legal_fn[$urandom_range(0, 4)]; end
                1: w[31:26] = 6'h00;
                2: w[31:26] = 6'h08;
                3: w[31:26] = 6'h23;
                4: w[31:26] = 6'h2b;
                5: w[31:26] = 6'h04;
                6: w[31:26] = 6'h02;
                default: ;
            endcase
            run_instr(w, $urandom_range(0, 3), -1);
        end

        // Abort a store two cycles into its memory stall, then wrap the counter.
        run_instr(32'hAD090008, 5, 5);
        do_reset(16'hFFFF, 1'b1);
        run_instr(32'h08000020, 0, -1);
        run_instr(32'h01095020, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes occur on the rising edge of clk.
REQ-002 Port: clk  input  1  system clock, rising-edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset.
REQ-004 Port: ins  input  32  instruction word from the fetch stage (yIF ins output).
REQ-005 Port: zero  input  1  ALU zero flag from the execute stage.
REQ-006 Port: mem_ready  input  1  data-memory access complete.
REQ-007 Port: RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, branch, jump, INT  output  1 each  datapath controls, same meanings as the single-cycle datapath.
REQ-008 Port: op  output  3  ALU operation select.
REQ-009 Port: ir_write  output  1  latch ins into internal IR.
REQ-010 Port: pc_write  output  1  PC register load enable.
REQ-011 Port: retire  output  1  one-cycle pulse when an instruction completes.
REQ-012 Port: illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-013 Port: instr_count  output  16  count of retired instructions.
REQ-014 Port: state  output  3  current FSM state, for debug.

Function
REQ-015 SHALL implement the states BOOT, FETCH, DECODE, EXEC, MEM, WB.
REQ-016 BOOT SHALL last one cycle with INT=1 and pc_write=1 (PC loads entryPoint), then go to FETCH.
REQ-017 FETCH SHALL assert ir_write=1 for one cycle; the IR captures ins; next state DECODE.
REQ-018 DECODE SHALL dispatch on IR[31:26]:
- j (0x2): jump=1, pc_write=1, retire=1 in DECODE; then FETCH.
- 0x0, 0x4, 0x8, 0x23, 0x2b: go to EXEC.
- any other opcode: illegal=1, pc_write=1 (PC+4), retire=0; then FETCH.
REQ-019 EXEC SHALL drive ALUSrc=0 for R-type and beq, and ALUSrc=1 otherwise.
REQ-020 EXEC for beq SHALL drive branch=1, pc_write=1, retire=1, op=110; next state FETCH. The taken/not-taken decision is made by yPC from zero.
REQ-021 EXEC next state: R-type and addi go to WB; lw and sw go to MEM.
REQ-022 MEM for lw SHALL hold MemRead=1 until mem_ready=1, then go to WB.
REQ-023 MEM for sw SHALL hold MemWrite=1 only in the cycle mem_ready=1; that cycle also drives pc_write=1 and retire=1; next state FETCH.
REQ-024 While mem_ready=0, MEM SHALL stall indefinitely with all other strobes at 0.
REQ-025 WB SHALL drive RegWrite=1, pc_write=1 and retire=1 for one cycle; next state FETCH.
REQ-026 WB SHALL drive RegDst=1 for R-type and RegDst=0 otherwise.
REQ-027 WB SHALL drive Mem2Reg=1 for lw only.
REQ-028 op SHALL be set as follows:
- R-type funct 0x20: 010; 0x22: 110; 0x24: 000; 0x25: 001; 0x2a: 111.
- lw, sw, addi: 010.
REQ-029 An R-type with any other funct SHALL pulse illegal in DECODE and retire without writing any register.
REQ-030 RegWrite, MemWrite, pc_write, retire and illegal SHALL each be high for at most one cycle per instruction.
REQ-031 Any control output not named for the current state SHALL be 0.
REQ-032 Latencies in cycles, including FETCH: j 2, beq 3, R-type/addi 4, sw 4 + stall, lw 5 + stall.
REQ-033 instr_count SHALL increment on each retire and wrap from 0xFFFF to 0x0000.
REQ-034 The IR SHALL change only in FETCH; a change on ins in any other state SHALL have no effect.

Reset
REQ-035 When rst_n=0 at a clock edge, the block SHALL enter BOOT from any state, including MEM mid-stall.
REQ-036 Under reset, the in-flight instruction SHALL be aborted, with no write strobe issued on that edge.
REQ-037 Under reset, the IR SHALL clear to 0 and instr_count to 0.
REQ-038 While rst_n=0, all outputs SHALL be 0 and state SHALL read BOOT; INT and pc_write assert only in the first cycle after release.

Structure
REQ-039 A shared package SHALL hold the state encoding, the opcode constants (0x0, 0x2, 0x4, 0x8, 0x23, 0x2b), the funct constants and the 3-bit ALU op codes.
REQ-040 Sub-module mc_alu_decode (combinational: opcode + funct -> op, funct_ok) SHALL be instantiated once.
REQ-041 The implementation SHALL use registered state and IR, with Moore outputs decoded from state and IR.

Verification
REQ-042 Reset release, then ins=0x01095020 (add) -> BOOT(INT=1), F, D, E, WB(RegWrite=1, RegDst=1, op=010); retire at cycle 5; instr_count=1.
REQ-043 lw 0x8D090004 with mem_ready low for 3 cycles -> MemRead held 4 cycles; WB with Mem2Reg=1; total 8 cycles from FETCH to retire.
REQ-044 beq 0x1109FFFE, then j 0x08000020 -> branch=1, op=110 in EXEC at cycle 3; jump=1, pc_write=1 in DECODE at cycle 2.
REQ-045 Opcode 0x3F and R-type funct 0x3F -> illegal pulses once each; RegWrite never asserted; instr_count unchanged by the opcode-0x3F instruction.
REQ-046 rst_n low during a MEM stall of sw -> MemWrite never asserted; state=BOOT; instr_count=0; after preload 0xFFFF, one retire -> 0x0000.
